demux8_32b_buf: RTL

//   1:8 demultiplexer for 32-bit words, the write-side counterpart of mux8_32b: routes one input word to one of eight output lanes.

---
 rtl/demux8_32b_buf_if.sv | 35 +++
 rtl/demux8_32b_buf.sv | 86 ++++++++
 2 files changed

// File: rtl/demux8_32b_buf_if.sv
// demux8_32b_buf_if
//   Bundles the producer-side handshake and the eight-lane output bus of
//   demux8_32b_buf, plus the two status outputs.
//   Ports (signals):
//     in_valid, in_ready, in_data, in_sel   producer handshake and routing
//     out_valid, out_ready, out_data         eight-lane consumer handshake,
//                                            lane i at out_data[WIDTH*i +: WIDTH]
//     xfer_count, busy                       status
//   Modports:
//     slave  - the demux itself
//     master - the environment (producer + consumers)
interface demux8_32b_buf_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [2:0]         in_sel;
  logic [7:0]         out_valid;
  logic [7:0]         out_ready;
  logic [8*WIDTH-1:0] out_data;
  logic [CNT_W-1:0]   xfer_count;
  logic               busy;

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, xfer_count, busy
  );

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, xfer_count, busy
  );
endinterface

// File: rtl/demux8_32b_buf.sv
// demux8_32b_buf
//   1:8 demultiplexer for WIDTH-bit words. One input word is routed to the
//   lane chosen by in_sel; every lane owns a one-entry holding register with
//   its own valid/ready handshake, so the producer and the eight consumers are
//   decoupled and a stalled lane never blocks the others.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous reset, active low (clears valid bits, data, counter)
//     bus    demux8_32b_buf_if.slave:
//              in_valid/in_ready/in_data/in_sel  producer side
//              out_valid/out_ready/out_data      eight consumer lanes
//              xfer_count                        accepted words, wraps
//              busy                              any lane holding a word
module demux8_32b_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  demux8_32b_buf_if.slave   bus
);

  logic [7:0]       valid_q, valid_d;
  logic [WIDTH-1:0] data_q [8];
  logic [WIDTH-1:0] data_d [8];
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_w;
  logic             accept;

  // A lane can take a new word if it is empty or being drained this same
  // cycle; the latter is what lets a lane stream without bubbles.
  always_comb begin
    in_ready_w = ~valid_q[bus.in_sel] | bus.out_ready[bus.in_sel];
    accept     = bus.in_valid & in_ready_w;
  end

  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    for (int i = 0; i < 8; i++) begin
      data_d[i] = data_q[i];
      // A drain with no reload empties the lane; data is left in place so
      // consumers must qualify it with out_valid.
      if (valid_q[i] & bus.out_ready[i]) begin
        valid_d[i] = 1'b0;
      end
      // Reload takes priority over drain on the same lane.
      if (accept && (bus.in_sel == 3'(i))) begin
        valid_d[i] = 1'b1;
        data_d[i]  = bus.in_data;
      end
    end
    if (accept) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < 8; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < 8; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign bus.out_data[WIDTH*gi +: WIDTH] = data_q[gi];
    end
  endgenerate

  assign bus.in_ready   = in_ready_w;
  assign bus.out_valid  = valid_q;
  assign bus.xfer_count = count_q;
  assign bus.busy       = |valid_q;

endmodule
